// File: rtl/spk_in.sv
// NoC ingress: buffers spk_out flits in a first-word-fall-through FIFO, returns credits,
// and dispatches each flit in order to the spike, data, config-write or config-read channel.
module spk_in #(
  parameter int unsigned B     = 4,
  parameter int unsigned FW    = 59,
  parameter int unsigned FTW   = 3,
  parameter int unsigned SW    = 24,
  parameter int unsigned R_FLG = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flit_in_wr,
  input  logic [FW-1:0]    flit_in,
  output logic             credit_out,
  output logic             spk_valid,
  output logic [SW-1:0]    spk_neuid,
  input  logic             spk_ready,
  output logic             data_valid,
  output logic [R_FLG-1:0] data_payload,
  output logic             data_last,
  input  logic             data_ready,
  output logic             cfg_wr_valid,
  output logic [R_FLG-1:0] cfg_wr_data,
  input  logic             cfg_wr_ready,
  output logic             cfg_rd_valid,
  output logic [FW-1:0]    cfg_rd_flit,
  input  logic             cfg_rd_ready,
  output logic             fifo_empty,
  output logic             ovf_err,
  output logic             proto_err,
  output logic             dbg_state
);

  localparam int unsigned DEPTH = 1 << B;
  localparam logic [FTW-1:0] T_SPIKE    = 'b000;
  localparam logic [FTW-1:0] T_DATA     = 'b001;
  localparam logic [FTW-1:0] T_DATA_END = 'b010;
  localparam logic [FTW-1:0] T_WRITE    = 'b110;
  localparam logic [FTW-1:0] T_READ     = 'b111;

  typedef enum logic {S_IDLE = 1'b0, S_PKT = 1'b1} state_e;

  // Handshake: each channel transfers in a cycle where valid & ready are both high at the
  // rising clock edge; valid and data are held stable until that transfer happens.

  logic [FW-1:0]    mem_q [DEPTH];
  logic [B-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [B:0]       count_q, count_d;
  state_e           state_q, state_d;
  logic             credit_q, credit_d;
  logic             spk_valid_q, spk_valid_d;
  logic [SW-1:0]    spk_neuid_q, spk_neuid_d;
  logic             data_valid_q, data_valid_d;
  logic [R_FLG-1:0] data_payload_q, data_payload_d;
  logic             data_last_q, data_last_d;
  logic             cfg_wr_valid_q, cfg_wr_valid_d;
  logic [R_FLG-1:0] cfg_wr_data_q, cfg_wr_data_d;
  logic             cfg_rd_valid_q, cfg_rd_valid_d;
  logic [FW-1:0]    cfg_rd_flit_q, cfg_rd_flit_d;
  logic             ovf_err_q, ovf_err_d;
  logic             proto_err_q, proto_err_d;

  logic [FW-1:0]    head;
  logic [FTW-1:0]   head_type;
  logic             empty, full, push, pop, target_free;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    head_type = head[FW-1 -: FTW];
    empty     = (count_q == '0);
    full      = (count_q == (B+1)'(DEPTH));

    // Unknown types target nothing, so they always drain.
    case (head_type)
      T_SPIKE:              target_free = !spk_valid_q || spk_ready;
      T_DATA, T_DATA_END:   target_free = !data_valid_q || data_ready;
      T_WRITE:              target_free = !cfg_wr_valid_q || cfg_wr_ready;
      T_READ:               target_free = !cfg_rd_valid_q || cfg_rd_ready;
      default:              target_free = 1'b1;
    endcase

    pop  = !empty && target_free;
    push = flit_in_wr && (!full || pop);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (B+1)'(push) - (B+1)'(pop);
    credit_d = pop;

    spk_valid_d    = spk_valid_q && !spk_ready;
    spk_neuid_d    = spk_neuid_q;
    data_valid_d   = data_valid_q && !data_ready;
    data_payload_d = data_payload_q;
    data_last_d    = data_last_q;
    cfg_wr_valid_d = cfg_wr_valid_q && !cfg_wr_ready;
    cfg_wr_data_d  = cfg_wr_data_q;
    cfg_rd_valid_d = cfg_rd_valid_q && !cfg_rd_ready;
    cfg_rd_flit_d  = cfg_rd_flit_q;
    state_d        = state_q;
    ovf_err_d      = ovf_err_q || (flit_in_wr && full && !pop);
    proto_err_d    = proto_err_q;

    if (pop) begin
      case (head_type)
        T_SPIKE: begin
          spk_valid_d = 1'b1;
          spk_neuid_d = head[SW-1:0];
        end
        T_DATA: begin
          data_valid_d   = 1'b1;
          data_payload_d = head[R_FLG-1:0];
          data_last_d    = 1'b0;
          state_d        = S_PKT;
        end
        T_DATA_END: begin
          data_valid_d   = 1'b1;
          data_payload_d = head[R_FLG-1:0];
          data_last_d    = 1'b1;
          state_d        = S_IDLE;
        end
        T_WRITE: begin
          cfg_wr_valid_d = 1'b1;
          cfg_wr_data_d  = head[R_FLG-1:0];
          if (state_q == S_PKT) proto_err_d = 1'b1;
        end
        T_READ: begin
          cfg_rd_valid_d = 1'b1;
          cfg_rd_flit_d  = head;
          if (state_q == S_PKT) proto_err_d = 1'b1;
        end
        default: proto_err_d = 1'b1;
      endcase
    end
  end

  // Storage array carries no reset; only pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= flit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= S_IDLE;
      credit_q       <= 1'b0;
      spk_valid_q    <= 1'b0;
      spk_neuid_q    <= '0;
      data_valid_q   <= 1'b0;
      data_payload_q <= '0;
      data_last_q    <= 1'b0;
      cfg_wr_valid_q <= 1'b0;
      cfg_wr_data_q  <= '0;
      cfg_rd_valid_q <= 1'b0;
      cfg_rd_flit_q  <= '0;
      ovf_err_q      <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      credit_q       <= credit_d;
      spk_valid_q    <= spk_valid_d;
      spk_neuid_q    <= spk_neuid_d;
      data_valid_q   <= data_valid_d;
      data_payload_q <= data_payload_d;
      data_last_q    <= data_last_d;
      cfg_wr_valid_q <= cfg_wr_valid_d;
      cfg_wr_data_q  <= cfg_wr_data_d;
      cfg_rd_valid_q <= cfg_rd_valid_d;
      cfg_rd_flit_q  <= cfg_rd_flit_d;
      ovf_err_q      <= ovf_err_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign credit_out   = credit_q;
  assign spk_valid    = spk_valid_q;
  assign spk_neuid    = spk_neuid_q;
  assign data_valid   = data_valid_q;
  assign data_payload = data_payload_q;
  assign data_last    = data_last_q;
  assign cfg_wr_valid = cfg_wr_valid_q;
  assign cfg_wr_data  = cfg_wr_data_q;
  assign cfg_rd_valid = cfg_rd_valid_q;
  assign cfg_rd_flit  = cfg_rd_flit_q;
  assign fifo_empty   = empty;
  assign ovf_err      = ovf_err_q;
  assign proto_err    = proto_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spk_in.sv
// Directed bench for spk_in: per-channel expected queues filled at write time and
// drained by a monitor on every handshake, plus flag, latency and reset checks.
module tb_spk_in;

  localparam int FW = 59;
  localparam int SW = 24;
  localparam int RF = 36;

  logic          clk, rst_n;
  logic          flit_in_wr;
  logic [FW-1:0] flit_in;
  logic          credit_out;
  logic          spk_valid, spk_ready;
  logic [SW-1:0] spk_neuid;
  logic          data_valid, data_last, data_ready;
  logic [RF-1:0] data_payload;
  logic          cfg_wr_valid, cfg_wr_ready;
  logic [RF-1:0] cfg_wr_data;
  logic          cfg_rd_valid, cfg_rd_ready;
  logic [FW-1:0] cfg_rd_flit;
  logic          fifo_empty, ovf_err, proto_err, dbg_state;

  int checks = 0;
  int errors = 0;
  int credit_cnt = 0;

  logic [SW-1:0] spk_exp_q[$];
  logic [RF:0]   data_exp_q[$];
  logic [RF-1:0] cfg_wr_exp_q[$];
  logic [FW-1:0] cfg_rd_exp_q[$];

  spk_in dut (
    .clk(clk), .rst_n(rst_n), .flit_in_wr(flit_in_wr), .flit_in(flit_in),
    .credit_out(credit_out),
    .spk_valid(spk_valid), .spk_neuid(spk_neuid), .spk_ready(spk_ready),
    .data_valid(data_valid), .data_payload(data_payload), .data_last(data_last),
    .data_ready(data_ready),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_data(cfg_wr_data), .cfg_wr_ready(cfg_wr_ready),
    .cfg_rd_valid(cfg_rd_valid), .cfg_rd_flit(cfg_rd_flit), .cfg_rd_ready(cfg_rd_ready),
    .fifo_empty(fifo_empty), .ovf_err(ovf_err), .proto_err(proto_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [2:0] t, input logic [RF-1:0] p);
    logic [19:0] route;
    route = 20'($urandom());
    return {t, route, p};
  endfunction

  // driver: one flit per call, back-to-back when called consecutively
  task automatic push_flit(input logic [FW-1:0] f, input bit drop);
    flit_in_wr = 1'b1;
    flit_in    = f;
    if (!drop) begin
      case (f[FW-1 -: 3])
        3'b000: spk_exp_q.push_back(f[SW-1:0]);
        3'b001: data_exp_q.push_back({1'b0, f[RF-1:0]});
        3'b010: data_exp_q.push_back({1'b1, f[RF-1:0]});
        3'b110: cfg_wr_exp_q.push_back(f[RF-1:0]);
        3'b111: cfg_rd_exp_q.push_back(f);
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    flit_in_wr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((spk_exp_q.size() + data_exp_q.size() + cfg_wr_exp_q.size() +
            cfg_rd_exp_q.size()) != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout observed=%0d pending expected=0", spk_exp_q.size() +
               data_exp_q.size() + cfg_wr_exp_q.size() + cfg_rd_exp_q.size());
    end
    cyc(3);
  endtask

  // scoreboard: compare every completed handshake against the head of its queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (credit_out) credit_cnt++;
      if (spk_valid && spk_ready) begin
        if (spk_exp_q.size() == 0) chk("spk_unexpected", 64'(spk_neuid), 64'h1_0000_0000);
        else chk("spk_neuid", 64'(spk_neuid), 64'(spk_exp_q.pop_front()));
      end
      if (data_valid && data_ready) begin
        if (data_exp_q.size() == 0) chk("data_unexpected", 64'(data_payload), 64'hDEAD);
        else chk("data_last_payload", 64'({data_last, data_payload}),
                 64'(data_exp_q.pop_front()));
      end
      if (cfg_wr_valid && cfg_wr_ready) begin
        if (cfg_wr_exp_q.size() == 0) chk("cfg_wr_unexpected", 64'(cfg_wr_data), 64'hDEAD);
        else chk("cfg_wr_data", 64'(cfg_wr_data), 64'(cfg_wr_exp_q.pop_front()));
      end
      if (cfg_rd_valid && cfg_rd_ready) begin
        if (cfg_rd_exp_q.size() == 0) chk("cfg_rd_unexpected", 64'(cfg_rd_flit), 64'hDEAD);
        else chk("cfg_rd_flit", 64'(cfg_rd_flit), 64'(cfg_rd_exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [FW-1:0] rd_flit;
    logic [FW-1:0] rd_flit_b;
    rst_n = 1'b0; flit_in_wr = 1'b0; flit_in = '0;
    spk_ready = 1'b1; data_ready = 1'b1; cfg_wr_ready = 1'b1; cfg_rd_ready = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // reset state
    chk("rst_valids", 64'({spk_valid, data_valid, cfg_wr_valid, cfg_rd_valid, credit_out}), 0);
    chk("rst_flags", 64'({ovf_err, proto_err, data_last, dbg_state}), 0);
    chk("rst_fifo_empty", 64'(fifo_empty), 1);

    // single spike: valid and credit two cycles after the write
    push_flit(mk(3'b000, 36'h0_0000_ABCD), 1'b0);
    chk("spk_lat_c1", 64'({spk_valid, credit_out}), 0);
    cyc(1);
    chk("spk_lat_c2_valid", 64'(spk_valid), 1);
    chk("spk_lat_c2_id", 64'(spk_neuid), 64'h00ABCD);
    chk("spk_lat_c2_credit", 64'(credit_out), 1);
    cyc(1);
    chk("spk_after_accept", 64'({spk_valid, credit_out}), 0);
    wait_drain(20);

    // fill: blocker occupies spike register, then 16 more fill the FIFO
    spk_ready = 1'b0;
    push_flit(mk(3'b000, 36'($urandom_range(0, 24'hFFFFFF))), 1'b0);
    cyc(3);
    credit_cnt = 0;
    for (int i = 0; i < 16; i++)
      push_flit(mk(3'b000, 36'($urandom_range(0, 24'hFFFFFF))), 1'b0);
    cyc(2);
    chk("fill_no_credit", 64'(credit_cnt), 0);
    chk("fill_not_empty", 64'(fifo_empty), 0);
    chk("fill_no_ovf", 64'(ovf_err), 0);
    push_flit(mk(3'b000, 36'h0_00FF_FFFF), 1'b1);
    chk("ovf_set", 64'(ovf_err), 1);
    spk_ready = 1'b1;
    wait_drain(60);
    chk("drain_credits", 64'(credit_cnt), 16);
    chk("drain_empty", 64'(fifo_empty), 1);
    chk("ovf_sticky", 64'(ovf_err), 1);

    // legal burst
    push_flit(mk(3'b001, 36'h1), 1'b0);
    push_flit(mk(3'b001, 36'h2), 1'b0);
    chk("burst_in_pkt", 64'(dbg_state), 1);
    push_flit(mk(3'b010, 36'h3), 1'b0);
    wait_drain(30);
    chk("burst_idle", 64'(dbg_state), 0);
    chk("burst_no_proto", 64'(proto_err), 0);

    // WRITE inside a burst
    push_flit(mk(3'b001, 36'h11), 1'b0);
    push_flit(mk(3'b110, 36'hC_AFE0_1234), 1'b0);
    push_flit(mk(3'b010, 36'h22), 1'b0);
    wait_drain(30);
    chk("burst_write_proto", 64'(proto_err), 1);
    chk("burst_write_idle", 64'(dbg_state), 0);

    // READ flit delivered bit-exact; second READ holds the spike behind it
    cfg_rd_ready = 1'b0;
    rd_flit   = (59'h7 << 56) | 59'h5A;
    rd_flit_b = mk(3'b111, 36'h9_8765_4321);
    push_flit(rd_flit, 1'b0);
    push_flit(rd_flit_b, 1'b0);
    push_flit(mk(3'b000, 36'h0_0012_3456), 1'b0);
    cyc(5);
    chk("rd_valid", 64'(cfg_rd_valid), 1);
    chk("rd_flit_exact", 64'(cfg_rd_flit), 64'(rd_flit));
    chk("rd_blocks_spike", 64'(spk_valid), 0);
    chk("rd_blocks_fifo", 64'(fifo_empty), 0);
    cfg_rd_ready = 1'b1;
    wait_drain(30);

    // reset, then unknown type
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("rst2_flags", 64'({ovf_err, proto_err}), 0);
    credit_cnt = 0;
    push_flit(mk(3'b011, 36'h77), 1'b0);
    cyc(3);
    chk("unk_proto", 64'(proto_err), 1);
    chk("unk_credit", 64'(credit_cnt), 1);
    chk("unk_no_valid", 64'({spk_valid, data_valid, cfg_wr_valid, cfg_rd_valid}), 0);

    // reset mid-burst with flits queued
    data_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_flit(mk(3'b001, 36'(i + 'h40)), 1'b0);
    cyc(2);
    chk("midburst_valid", 64'(data_valid), 1);
    chk("midburst_queued", 64'(fifo_empty), 0);
    rst_n = 1'b0;
    data_exp_q.delete();
    #1;
    chk("rst3_outputs", 64'({spk_valid, data_valid, cfg_wr_valid, cfg_rd_valid, credit_out,
                             ovf_err, proto_err, data_last, dbg_state}), 0);
    chk("rst3_payloads", 64'(data_payload) | 64'(spk_neuid) | 64'(cfg_wr_data), 0);
    chk("rst3_rd_flit", 64'(cfg_rd_flit), 0);
    chk("rst3_fifo_empty", 64'(fifo_empty), 1);
    cyc(2);
    rst_n = 1'b1;
    data_ready = 1'b1;
    cyc(5);
    chk("post_rst_quiet", 64'({spk_valid, data_valid, cfg_wr_valid, cfg_rd_valid}), 0);
    chk("post_rst_empty", 64'(fifo_empty), 1);

    chk("queues_empty", 64'(spk_exp_q.size() + data_exp_q.size() + cfg_wr_exp_q.size() +
                            cfg_rd_exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
